// File: rtl/potential_decay_array.sv
// Multi-neuron LIF membrane-potential store with a timestep sweep that decays, writes back and streams every neuron.
// Optional 0.75x decay path is built when DECAY_THREE_QUARTER_EN is defined.
module potential_decay_array #(
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              init_valid,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [31:0]       init_potential,
    input  logic [3:0]        init_rate,
    input  logic              acc_valid,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [31:0]       acc_potential,
    output logic              wr_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_potential,
    output logic              busy,
    output logic              done
);

    localparam int unsigned FP_W = 32;
    localparam int unsigned RATE_W = 4;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        FLUSH
    } state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   idx, idx_d;
    logic                out_valid_d, busy_d, done_d;
    logic [ADDR_W-1:0]   out_addr_d;
    logic [FP_W-1:0]     out_potential_d;
    logic                wb_en;
    logic                wr_open;
    logic [FP_W-1:0]     cur_pot;
    logic [RATE_W-1:0]   cur_rate;
    logic [FP_W-1:0]     dec_pot;

    logic [FP_W-1:0]     pot  [NUM_NEURONS];
    logic [RATE_W-1:0]   rate [NUM_NEURONS];

    // Decay one float32; truncating, with underflow flushed to +0.
    function automatic logic [FP_W-1:0] decay(input logic [FP_W-1:0] x, input logic [RATE_W-1:0] r);
        logic       s;
        logic [7:0] e;
        logic [22:0] m;
        logic [7:0] k;
`ifdef DECAY_THREE_QUARTER_EN
        logic [25:0] p;
`else
        logic       unused_sel;
`endif
        s = x[31];
        e = x[30:23];
        m = x[22:0];
        k = 8'(r[2:0]);
        decay = x;
`ifdef DECAY_THREE_QUARTER_EN
        p = 26'({1'b1, m}) * 26'd3;
`else
        unused_sel = r[3];
`endif
        if (e == 8'hFF) begin
            decay = x;
        end else if (e == 8'h00) begin
            decay = '0;
        end
`ifdef DECAY_THREE_QUARTER_EN
        else if (r[3]) begin
            if (p[25]) begin
                decay = {s, e, p[24:2]};
            end else if (e == 8'd1) begin
                decay = '0;
            end else begin
                decay = {s, e - 8'd1, p[23:1]};
            end
        end
`endif
        else if (e <= k) begin
            decay = '0;
        end else begin
            decay = {s, e - k, m};
        end
    endfunction

    // Read port for the neuron currently being swept.
    always_comb begin
        cur_pot  = '0;
        cur_rate = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (idx == ADDR_W'(i)) begin
                cur_pot  = pot[i];
                cur_rate = rate[i];
            end
        end
    end

    assign dec_pot = decay(cur_pot, cur_rate);
    assign wr_open = (state == IDLE);

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state;
        idx_d           = idx;
        out_valid_d     = out_valid;
        out_addr_d      = out_addr;
        out_potential_d = out_potential;
        busy_d          = busy;
        done_d          = 1'b0;
        wb_en           = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                if (!out_valid || out_ready) begin
                    out_valid_d     = 1'b1;
                    out_addr_d      = idx;
                    out_potential_d = dec_pot;
                    wb_en           = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_d = FLUSH;
                    end else begin
                        idx_d = idx + ADDR_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_potential <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            wr_ready      <= 1'b1;
        end else begin
            state         <= state_d;
            idx           <= idx_d;
            out_valid     <= out_valid_d;
            out_addr      <= out_addr_d;
            out_potential <= out_potential_d;
            busy          <= busy_d;
            done          <= done_d;
            wr_ready      <= !busy_d;
        end
    end

    // Storage: sweep write-back, else init (wins over acc), else acc; out-of-range addresses match nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot[i]  <= '0;
                rate[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (wb_en && (idx == ADDR_W'(i))) begin
                    pot[i] <= dec_pot;
                end else if (wr_open && init_valid && (init_addr == ADDR_W'(i))) begin
                    pot[i]  <= init_potential;
                    rate[i] <= init_rate;
                end else if (wr_open && acc_valid && (acc_addr == ADDR_W'(i))) begin
                    pot[i] <= acc_potential;
                end
            end
        end
    end

endmodule
